// File: rtl/tag_ct_merge_pkg.sv
// Shared helpers for tag/count merge logic and round-robin arbiters.
package tag_ct_merge_pkg;

  // Modular increment: next index after idx in a ring of n entries.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

  // Saturating increment of a counter that is w bits wide (w <= 64).
  function automatic logic [63:0] sat_inc(input logic [63:0] val, input int unsigned w);
    logic [63:0] max_v;
    max_v = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (val >= max_v) ? max_v : val + 64'd1;
  endfunction

endpackage

// File: rtl/tag_ct_merge_rr_if.sv
// Tag/count valid-ack channel. The source drives tag/ct/v, the sink drives a.
interface TagCtChannel #(
  parameter int Ntag = 11,
  parameter int Nct  = 10
) ();
  logic [Ntag-1:0] tag;
  logic [Nct-1:0]  ct;
  logic            v;
  logic            a;

  modport master (output tag, output ct, output v, input a);
  modport slave  (input tag, input ct, input v, output a);
endinterface

// File: rtl/tag_ct_merge_rr_arb.sv
// Combinational round-robin arbiter: first requester found scanning from ptr upward.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx
);
  logic         found;
  logic [W-1:0] cand;

  // Scan the ring starting at ptr; the first request wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = W'((int'(ptr) + k) % N);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end
endmodule

// File: rtl/tag_ct_merge_rr.sv
// N-way round-robin merge of tag/count streams into one registered output,
// with optional same-tag coalescing into a stalled held token.
module tag_ct_merge_rr
  import tag_ct_merge_pkg::*;
#(
  parameter int NIN      = 4,
  parameter int Ntag     = 11,
  parameter int Nct      = 10,
  parameter int COALESCE = 1,
  parameter int Nmc      = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  TagCtChannel.slave        in [NIN],
  TagCtChannel.master       out,
  output logic [Nmc-1:0]    merge_count
);
  localparam int PTR_W = (NIN > 1) ? $clog2(NIN) : 1;

  logic [Ntag-1:0]  in_tag [NIN];
  logic [Nct-1:0]   in_ct  [NIN];
  logic [NIN-1:0]   in_v;
  logic [NIN-1:0]   req;
  logic [NIN-1:0]   gnt;
  logic [PTR_W-1:0] gidx;
  logic [PTR_W-1:0] ptr;

  logic             hold_v;
  logic [Ntag-1:0]  hold_tag;
  logic [Nct-1:0]   hold_ct;

  logic             fire;
  logic             slot_free;
  logic             grant;
  logic [Nct:0]     sum_c;
  logic [Nct:0]     sum_g;
  logic [Ntag-1:0]  g_tag;
  logic [Nct-1:0]   g_ct;
  logic [63:0]      mc_inc;

  // Flatten the interface array; acks are just the arbiter grant.
  for (genvar i = 0; i < NIN; i++) begin : g_in
    assign in_tag[i] = in[i].tag;
    assign in_ct[i]  = in[i].ct;
    assign in_v[i]   = in[i].v;
    assign in[i].a   = gnt[i];
  end

  assign out.v   = hold_v;
  assign out.tag = hold_tag;
  assign out.ct  = hold_ct;

  assign fire      = hold_v && out.a;
  assign slot_free = !hold_v || fire;

  // Acceptability: free slot, or a same-tag merge into a stalled token that
  // does not overflow. Reset masks every request so no ack is raised.
  always_comb begin
    req   = '0;
    sum_c = '0;
    for (int i = 0; i < NIN; i++) begin
      sum_c = {1'b0, hold_ct} + {1'b0, in_ct[i]};
      req[i] = reset_n && in_v[i] &&
               (slot_free ||
                ((COALESCE != 0) && hold_v && !fire &&
                 (in_tag[i] == hold_tag) && !sum_c[Nct]));
    end
  end

  rr_arbiter #(.N(NIN), .W(PTR_W)) u_arb (
    .req (req),
    .ptr (ptr),
    .gnt (gnt),
    .idx (gidx)
  );

  assign grant  = |gnt;
  assign g_tag  = in_tag[gidx];
  assign g_ct   = in_ct[gidx];
  assign sum_g  = {1'b0, hold_ct} + {1'b0, g_ct};
  assign mc_inc = sat_inc(64'(merge_count), Nmc);

  // Holding register, round-robin pointer and merge statistics.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hold_v      <= 1'b0;
      hold_tag    <= '0;
      hold_ct     <= '0;
      ptr         <= '0;
      merge_count <= '0;
    end else begin
      if (grant) begin
        if (slot_free) begin
          hold_v   <= 1'b1;
          hold_tag <= g_tag;
          hold_ct  <= g_ct;
        end else begin
          hold_ct     <= sum_g[Nct-1:0];
          merge_count <= mc_inc[Nmc-1:0];
        end
        ptr <= PTR_W'(rr_next(32'(gidx), NIN));
      end else if (fire) begin
        hold_v <= 1'b0;
      end
    end
  end
endmodule
